// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, RV32I
// funct3 width codes and the store byte-enable helper.
package lsu_pkg;

    // Access sequencing states, also exported on the debug port
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Stores enable only the addressed lanes; loads always fetch the full word
    function automatic logic [3:0] calc_be(input logic       is_store,
                                           input logic [2:0] f3,
                                           input logic [1:0] ofs);
        logic [3:0] be;
        be = 4'b1111;
        if (is_store) begin
            case (f3)
                F3_B:    be = 4'b0001 << ofs;
                F3_H:    be = 4'b0011 << ofs;
                default: be = 4'b1111;
            endcase
        end
        return be;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data formatter: picks the addressed byte/halfword out of the bus word
// and sign- or zero-extends it according to funct3. Purely combinational.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane selection and extension of the returned word
    always_comb begin
        sel_byte = rdata_i[7:0];
        sel_half = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (addr_i)
            2'd0:    sel_byte = rdata_i[7:0];
            2'd1:    sel_byte = rdata_i[15:8];
            2'd2:    sel_byte = rdata_i[23:16];
            default: sel_byte = rdata_i[31:24];
        endcase
        case (funct3_i)
            F3_B:    data_o = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    data_o = {{16{sel_half[15]}}, sel_half};
            F3_BU:   data_o = {24'h0, sel_byte};
            F3_HU:   data_o = {16'h0, sel_half};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage of the single-cycle core. Issues one data-bus transaction per
// load/store over a valid/ready request channel plus a response-valid channel,
// stalling the core until the access completes.
//
// Request handshake: dReqValid is high exactly while in REQ; address, data,
// byte enables and write enable are registered and do not change until the
// cycle in which dReqValid && dReqReady (transfer). A read response is taken
// only in WAIT, i.e. no earlier than the cycle after the transfer.
//
// Optional feature: define LSU_TIMEOUT_EN to abort a load whose response has
// not arrived after TIMEOUT_CYCLES cycles in WAIT, reporting lsuFault.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic            lsuReq,
    input  logic            memWrite,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] aluResult,
    input  logic [XLEN-1:0] writeData,
    output logic            lsuStall,
    output logic [XLEN-1:0] readData,
    output logic            lsuFault,
    output logic            dReqValid,
    input  logic            dReqReady,
    output logic            dWe,
    output logic [XLEN-1:0] dAddr,
    output logic [XLEN-1:0] dWData,
    output logic [3:0]      dBe,
    input  logic            dRspValid,
    input  logic [XLEN-1:0] dRData,
    output lsu_state_t      dbgState
);

    lsu_state_t      state_q, state_d;
    logic [XLEN-1:0] addr_q,  addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [3:0]      be_q,    be_d;
    logic            we_q,    we_d;
    logic [2:0]      f3_q,    f3_d;
    logic [1:0]      ofs_q,   ofs_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic            req_legal;
    logic            req_aligned;
    logic [XLEN-1:0] store_lanes;
    logic [XLEN-1:0] load_data;
    logic            timeout_hit;

    load_align u_load_align (
        .rdata_i  (dRData),
        .addr_i   (ofs_q),
        .funct3_i (f3_q),
        .data_o   (load_data)
    );

    // Decode legality, alignment and store lane replication of the new request
    always_comb begin
        req_legal   = 1'b0;
        req_aligned = 1'b1;
        store_lanes = writeData;
        case (funct3)
            F3_B, F3_H, F3_W: req_legal = 1'b1;
            F3_BU, F3_HU:     req_legal = !memWrite;
            default:          req_legal = 1'b0;
        endcase
        case (funct3)
            F3_H, F3_HU: req_aligned = !aluResult[0];
            F3_W:        req_aligned = (aluResult[1:0] == 2'b00);
            default:     req_aligned = 1'b1;
        endcase
        case (funct3)
            F3_B:    store_lanes = {4{writeData[7:0]}};
            F3_H:    store_lanes = {2{writeData[15:0]}};
            default: store_lanes = writeData;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CW-1:0] cnt_q, cnt_d;

    // Count WAIT cycles; cleared on the transfer that enters WAIT
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == REQ && dReqReady && !we_q) begin
            cnt_d = '0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Timeout counter register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
`endif

    // Next-state logic and request/result register updates
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        f3_d    = f3_q;
        ofs_d   = ofs_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (lsuReq) begin
                    rdata_d = '0;
                    if (req_legal && req_aligned) begin
                        state_d = REQ;
                        addr_d  = {aluResult[XLEN-1:2], 2'b00};
                        wdata_d = store_lanes;
                        be_d    = calc_be(memWrite, funct3, aluResult[1:0]);
                        we_d    = memWrite;
                        f3_d    = funct3;
                        ofs_d   = aluResult[1:0];
                        fault_d = 1'b0;
                    end else begin
                        // Illegal or misaligned: report without touching the bus
                        state_d = DONE;
                        fault_d = 1'b1;
                    end
                end
            end
            REQ: begin
                if (dReqReady) begin
                    state_d = we_q ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (dRspValid) begin
                    state_d = DONE;
                    rdata_d = load_data;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    fault_d = 1'b1;
                    rdata_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                fault_d = 1'b0;
            end
        endcase
    end

    // State and request registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            ofs_q   <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            ofs_q   <= ofs_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
        end
    end

    // The core is released only in DONE, including on the fault path, so the
    // fault pulse always lines up with the instruction that caused it.
    assign lsuStall  = lsuReq && (state_q != DONE);
    assign readData  = (state_q == DONE) ? rdata_q : '0;
    assign lsuFault  = (state_q == DONE) && fault_q;
    assign dReqValid = (state_q == REQ);
    assign dWe       = (state_q == REQ) && we_q;
    assign dAddr     = addr_q;
    assign dWData    = wdata_q;
    assign dBe       = be_q;
    assign dbgState  = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, loads of every width, fault
// cases, request back-pressure, asynchronous reset mid-access and the
// optional WAIT timeout (LSU_TIMEOUT_EN, built with TIMEOUT_CYCLES = 8).
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        resetN;
    logic        lsuReq;
    logic        memWrite;
    logic [2:0]  funct3;
    logic [31:0] aluResult;
    logic [31:0] writeData;
    logic        lsuStall;
    logic [31:0] readData;
    logic        lsuFault;
    logic        dReqValid;
    logic        dReqReady;
    logic        dWe;
    logic [31:0] dAddr;
    logic [31:0] dWData;
    logic [3:0]  dBe;
    logic        dRspValid;
    logic [31:0] dRData;
    lsu_state_t  dbgState;

    int          n_checks;
    int          n_pass;
    logic [31:0] exp_q[$];

    int          done_cyc;
    logic [31:0] rd;
    logic        flt;
    logic        saw_req;
    logic        stable;
    logic [31:0] s_addr;
    logic [3:0]  s_be;
    logic [31:0] s_wd;
    logic        s_we;

    load_store_unit #(
        .XLEN           (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .resetN    (resetN),
        .lsuReq    (lsuReq),
        .memWrite  (memWrite),
        .funct3    (funct3),
        .aluResult (aluResult),
        .writeData (writeData),
        .lsuStall  (lsuStall),
        .readData  (readData),
        .lsuFault  (lsuFault),
        .dReqValid (dReqValid),
        .dReqReady (dReqReady),
        .dWe       (dWe),
        .dAddr     (dAddr),
        .dWData    (dWData),
        .dBe       (dBe),
        .dRspValid (dRspValid),
        .dRData    (dRData),
        .dbgState  (dbgState)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    endtask

    // Drives one access from an IDLE cycle (entered #1 after a rising edge)
    // and plays the bus: ready after rdy_lat request cycles, response rsp_lat
    // cycles after the transfer. done_cyc = -1 if bound cycles pass first.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int rdy_lat, input int rsp_lat,
                          input logic [31:0] rword, input int bound,
                          output int dc, output logic [31:0] r, output logic f,
                          output logic sr, output logic st, output logic [31:0] sa,
                          output logic [3:0] sb, output logic [31:0] sw, output logic swe);
        int req_cycles;
        int acc_c;
        bit accepted;
        req_cycles = 0; acc_c = 0; accepted = 0;
        dc = -1; r = '0; f = 1'b0; sr = 1'b0; st = 1'b1;
        sa = '0; sb = '0; sw = '0; swe = 1'b0;
        lsuReq = 1'b1; memWrite = we; funct3 = f3; aluResult = a; writeData = wd;
        dReqReady = 1'b0; dRspValid = 1'b0; dRData = '0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (dReqValid) begin
                if (!sr) begin
                    sa = dAddr; sb = dBe; sw = dWData; swe = dWe; sr = 1'b1;
                end else if (dAddr !== sa || dBe !== sb || dWData !== sw || dWe !== swe) begin
                    st = 1'b0;
                end
                req_cycles++;
            end
            if (!lsuStall) begin
                dc = c; r = readData; f = lsuFault;
                dReqReady = 1'b0; dRspValid = 1'b0;
                break;
            end
            dReqReady = dReqValid && (req_cycles > rdy_lat);
            if (dReqReady) begin
                accepted = 1'b1;
                acc_c = c;
            end
            dRspValid = accepted && (c == acc_c + rsp_lat);
            dRData = dRspValid ? rword : 32'h0;
            @(posedge clk);
            #1;
        end
        if (dc >= 0) begin
            @(posedge clk);
            #1;
        end
        lsuReq = 1'b0; dReqReady = 1'b0; dRspValid = 1'b0;
    endtask

    // Main sequence
    initial begin
        n_checks = 0; n_pass = 0;
        resetN = 1'b0; lsuReq = 1'b0; memWrite = 1'b0; funct3 = '0;
        aluResult = '0; writeData = '0; dReqReady = 1'b0; dRspValid = 1'b0; dRData = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 32'(dbgState), 32'(IDLE));
        chk("rst_dReqValid", 32'(dReqValid), 0);
        chk("rst_dWe", 32'(dWe), 0);
        chk("rst_dAddr", dAddr, 0);
        chk("rst_dWData", dWData, 0);
        chk("rst_dBe", 32'(dBe), 0);
        chk("rst_readData", readData, 0);
        chk("rst_lsuFault", 32'(lsuFault), 0);
        resetN = 1'b1;
        @(posedge clk);
        #1;

        // SW, ready immediately: DONE at cycle 2
        access(1'b1, F3_W, 32'h100, 32'hDEADBEEF, 0, 1, 32'h0, 20,
               done_cyc, rd, flt, saw_req, stable, s_addr, s_be, s_wd, s_we);
        chk("sw_done_cyc", 32'(done_cyc), 2);
        chk("sw_be", 32'(s_be), 32'hF);
        chk("sw_wdata", s_wd, 32'hDEADBEEF);
        chk("sw_we", 32'(s_we), 1);
        chk("sw_addr", s_addr, 32'h100);
        chk("sw_fault", 32'(flt), 0);

        // SB back-to-back with the SW
        access(1'b1, F3_B, 32'h103, 32'h000000A5, 0, 1, 32'h0, 20,
               done_cyc, rd, flt, saw_req, stable, s_addr, s_be, s_wd, s_we);
        chk("sb_done_cyc", 32'(done_cyc), 2);
        chk("sb_be", 32'(s_be), 32'h8);
        chk("sb_wdata", s_wd, 32'hA5A5A5A5);
        chk("sb_addr", s_addr, 32'h100);

        // LW with 1-cycle response: DONE at cycle 3
        exp_q.push_back(32'hCAFEF00D);
        access(1'b0, F3_W, 32'h104, 32'h0, 0, 1, 32'hCAFEF00D, 20,
               done_cyc, rd, flt, saw_req, stable, s_addr, s_be, s_wd, s_we);
        chk("lw_done_cyc", 32'(done_cyc), 3);
        chk("lw_data", rd, exp_q.pop_front());
        chk("lw_we", 32'(s_we), 0);
        chk("lw_be", 32'(s_be), 32'hF);
        @(negedge clk);
        chk("idle_readData", readData, 0);
        @(posedge clk);
        #1;

        // LB / LBU with 3-cycle response delay
        exp_q.push_back(32'hFFFFFFF0);
        access(1'b0, F3_B, 32'h102, 32'h0, 0, 3, 32'h12F03456, 20,
               done_cyc, rd, flt, saw_req, stable, s_addr, s_be, s_wd, s_we);
        chk("lb_done_cyc", 32'(done_cyc), 5);
        chk("lb_data", rd, exp_q.pop_front());
        chk("lb_addr", s_addr, 32'h100);
        exp_q.push_back(32'h000000F0);
        access(1'b0, F3_BU, 32'h102, 32'h0, 0, 3, 32'h12F03456, 20,
               done_cyc, rd, flt, saw_req, stable, s_addr, s_be, s_wd, s_we);
        chk("lbu_data", rd, exp_q.pop_front());

        // Halfword loads
        exp_q.push_back(32'hFFFF8001);
        access(1'b0, F3_H, 32'h102, 32'h0, 0, 1, 32'h80010000, 20,
               done_cyc, rd, flt, saw_req, stable, s_addr, s_be, s_wd, s_we);
        chk("lh_data", rd, exp_q.pop_front());
        exp_q.push_back(32'h00008765);
        access(1'b0, F3_HU, 32'h100, 32'h0, 0, 1, 32'h12348765, 20,
               done_cyc, rd, flt, saw_req, stable, s_addr, s_be, s_wd, s_we);
        chk("lhu_data", rd, exp_q.pop_front());

        // Faults: no bus request, DONE in the next cycle
        access(1'b0, F3_H, 32'h101, 32'h0, 0, 1, 32'h0, 20,
               done_cyc, rd, flt, saw_req, stable, s_addr, s_be, s_wd, s_we);
        chk("lh_mis_fault", 32'(flt), 1);
        chk("lh_mis_noreq", 32'(saw_req), 0);
        chk("lh_mis_cyc", 32'(done_cyc), 1);
        chk("lh_mis_data", rd, 0);
        access(1'b0, F3_W, 32'h102, 32'h0, 0, 1, 32'h0, 20,
               done_cyc, rd, flt, saw_req, stable, s_addr, s_be, s_wd, s_we);
        chk("lw_mis_fault", 32'(flt), 1);
        chk("lw_mis_noreq", 32'(saw_req), 0);
        access(1'b0, 3'd3, 32'h100, 32'h0, 0, 1, 32'h0, 20,
               done_cyc, rd, flt, saw_req, stable, s_addr, s_be, s_wd, s_we);
        chk("f3_ill_fault", 32'(flt), 1);
        chk("f3_ill_noreq", 32'(saw_req), 0);
        access(1'b1, F3_BU, 32'h100, 32'h0, 0, 1, 32'h0, 20,
               done_cyc, rd, flt, saw_req, stable, s_addr, s_be, s_wd, s_we);
        chk("st_ill_fault", 32'(flt), 1);
        chk("st_ill_noreq", 32'(saw_req), 0);

        // SH with dReqReady low for 5 request cycles
        access(1'b1, F3_H, 32'h102, 32'h1234BEEF, 5, 1, 32'h0, 40,
               done_cyc, rd, flt, saw_req, stable, s_addr, s_be, s_wd, s_we);
        chk("sh_bp_done_cyc", 32'(done_cyc), 7);
        chk("sh_bp_stable", 32'(stable), 1);
        chk("sh_bp_be", 32'(s_be), 32'hC);
        chk("sh_bp_wdata", s_wd, 32'hBEEFBEEF);

        // Reset while in REQ: request drops at once
        lsuReq = 1'b1; memWrite = 1'b1; funct3 = F3_W; aluResult = 32'h300; dReqReady = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rreq_valid_pre", 32'(dReqValid), 1);
        #1 resetN = 1'b0;
        #1;
        chk("rreq_valid_post", 32'(dReqValid), 0);
        chk("rreq_state", 32'(dbgState), 32'(IDLE));
        lsuReq = 1'b0;
        @(posedge clk);
        #1 resetN = 1'b1;

        // Reset while in WAIT; a late response is ignored
        lsuReq = 1'b1; memWrite = 1'b0; funct3 = F3_W; aluResult = 32'h200; dReqReady = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 dReqReady = 1'b0;
        chk("rwait_state_pre", 32'(dbgState), 32'(WAIT));
        resetN = 1'b0;
        #1;
        chk("rwait_state_post", 32'(dbgState), 32'(IDLE));
        lsuReq = 1'b0;
        #2 resetN = 1'b1;
        dRspValid = 1'b1; dRData = 32'hFFFFFFFF;
        @(posedge clk);
        #1 dRspValid = 1'b0;
        @(negedge clk);
        chk("late_rsp_state", 32'(dbgState), 32'(IDLE));
        chk("late_rsp_data", readData, 0);
        chk("late_rsp_fault", 32'(lsuFault), 0);
        @(posedge clk);
        #1;

`ifdef LSU_TIMEOUT_EN
        // No response: abort after 8 WAIT cycles (cycles 2..9), DONE at 10
        access(1'b0, F3_W, 32'h400, 32'h0, 0, 100000, 32'h0, 50,
               done_cyc, rd, flt, saw_req, stable, s_addr, s_be, s_wd, s_we);
        chk("to_done_cyc", 32'(done_cyc), 10);
        chk("to_fault", 32'(flt), 1);
        chk("to_data", rd, 0);
        dRspValid = 1'b1; dRData = 32'h12345678;
        @(posedge clk);
        #1 dRspValid = 1'b0;
        @(negedge clk);
        chk("to_late_state", 32'(dbgState), 32'(IDLE));
        chk("to_late_data", readData, 0);
`else
        // No response and no timeout: the stall persists
        access(1'b0, F3_W, 32'h400, 32'h0, 0, 100000, 32'h0, 300,
               done_cyc, rd, flt, saw_req, stable, s_addr, s_be, s_wd, s_we);
        chk("nto_not_done", 32'(done_cyc), 32'hFFFFFFFF);
        lsuReq = 1'b1;
        @(negedge clk);
        chk("nto_stall", 32'(lsuStall), 1);
        chk("nto_state", 32'(dbgState), 32'(WAIT));
        lsuReq = 1'b0;
        resetN = 1'b0;
        #2 resetN = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
